pieo_op_tracker: RTL

- Parametrised outstanding-operation tracker for the PIEO scheduler path.
- Counts issued requests (triggers) against their completions (valids) on NUM_CH independent channels, for example PIEO enqueue and dequeue.
- Drives a global ready plus per-channel readies that gate the pre-enqueue and post-dequeue logic.
- Generalises the single-bit wait tracker: multi-outstanding depth, N channels, selectable ready mode, per-channel watchdog timeout, sticky protocol-error flags.

---
 rtl/pieo_op_tracker_if.sv | 25 ++
 rtl/pieo_op_tracker.sv | 81 ++++++++
 2 files changed

// File: rtl/pieo_op_tracker_if.sv
// pieo_op_tracker_if: trigger/valid request bus plus ready, count and sticky flag outputs of the tracker.
interface pieo_op_tracker_if #(
    parameter int NUM_CH    = 2,
    parameter int CNT_WIDTH = 1
);
    logic [NUM_CH-1:0]           trigger;
    logic [NUM_CH-1:0]           valid;
    logic                        err_clr;
    logic                        ready;
    logic [NUM_CH-1:0]           ch_ready;
    logic [NUM_CH-1:0]           ch_idle;
    logic [NUM_CH*CNT_WIDTH-1:0] count_out;
    logic [NUM_CH-1:0]           timeout_flag;
    logic [NUM_CH-1:0]           overflow_flag;
    logic [NUM_CH-1:0]           spurious_flag;

    modport master (
        output trigger, valid, err_clr,
        input  ready, ch_ready, ch_idle, count_out, timeout_flag, overflow_flag, spurious_flag
    );
    modport slave (
        input  trigger, valid, err_clr,
        output ready, ch_ready, ch_idle, count_out, timeout_flag, overflow_flag, spurious_flag
    );
endinterface

// File: rtl/pieo_op_tracker.sv
// pieo_op_tracker: per-channel outstanding-op counters with ready decode, completion watchdog and sticky error flags.
module pieo_op_tracker #(
    parameter int NUM_CH          = 2,
    parameter int MAX_OUTSTANDING = 1,
    parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1),
    parameter int READY_MODE      = 0,
    parameter int TIMEOUT_CYCLES  = 1024,
    parameter int TO_WIDTH        = $clog2(TIMEOUT_CYCLES + 1),
    parameter int TIMEOUT_FLUSH   = 1
) (
    input logic              clk,
    input logic              rst_n,
    pieo_op_tracker_if.slave bus
);
    localparam int WDW = (TO_WIDTH > 0) ? TO_WIDTH : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_OUTSTANDING);
    localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit WD_EN = TIMEOUT_CYCLES > 0;
    localparam bit FLUSH = TIMEOUT_FLUSH != 0;

    logic [NUM_CH-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [NUM_CH-1:0][WDW-1:0]       wd_q, wd_d;
    logic [NUM_CH-1:0] to_q, to_d, ov_q, ov_d, sp_q, sp_d;
    logic [NUM_CH-1:0] trig_ok, val_ok, wd_clr, expire, ch_rdy, ch_idl;

    always_comb begin
        trig_ok = '0;
        val_ok  = '0;
        wd_clr  = '0;
        expire  = '0;
        cnt_d   = cnt_q;
        wd_d    = wd_q;
        for (int i = 0; i < NUM_CH; i++) begin
            trig_ok[i] = bus.trigger[i] && (cnt_q[i] < CNT_MAX);
            val_ok[i]  = bus.valid[i] && (cnt_q[i] != '0);
            wd_clr[i]  = (cnt_q[i] == '0) || val_ok[i];
            // a completion on the expiry cycle wins over the timeout
            expire[i]  = WD_EN && !wd_clr[i] && (wd_q[i] == WD_LAST);
            wd_d[i]    = (!WD_EN || wd_clr[i] || expire[i]) ? '0 : wd_q[i] + 1'b1;
            cnt_d[i]   = (expire[i] && FLUSH)       ? '0 :
                         (trig_ok[i] && !val_ok[i]) ? cnt_q[i] + 1'b1 :
                         (val_ok[i] && !trig_ok[i]) ? cnt_q[i] - 1'b1 : cnt_q[i];
        end
        to_d = (to_q & ~{NUM_CH{bus.err_clr}}) | expire;
        ov_d = (ov_q & ~{NUM_CH{bus.err_clr}}) | (bus.trigger & ~trig_ok);
        sp_d = (sp_q & ~{NUM_CH{bus.err_clr}}) | (bus.valid & ~val_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            wd_q  <= '0;
            to_q  <= '0;
            ov_q  <= '0;
            sp_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            wd_q  <= wd_d;
            to_q  <= to_d;
            ov_q  <= ov_d;
            sp_q  <= sp_d;
        end
    end

    always_comb begin
        ch_rdy = '0;
        ch_idl = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_rdy[i] = cnt_q[i] < CNT_MAX;
            ch_idl[i] = cnt_q[i] == '0;
        end
    end

    assign bus.ch_ready      = ch_rdy;
    assign bus.ch_idle       = ch_idl;
    assign bus.ready         = (READY_MODE != 0) ? &ch_rdy : &ch_idl;
    assign bus.count_out     = cnt_q;
    assign bus.timeout_flag  = to_q;
    assign bus.overflow_flag = ov_q;
    assign bus.spurious_flag = sp_q;
endmodule
